// File: rtl/pl_pkg.sv
// Shared definitions for the MEM->WB elastic stage: payload layout, result-source
// encodings and the thread-count helper.
package pl_pkg;

    localparam int MW_ADDRESS_WIDTH = 32;
    localparam int MW_DATA_WIDTH    = 32;
    localparam int MW_BITS_THREADS  = 3;
    localparam int MW_REG_ADDR_W    = 5;

    function automatic int num_threads(input int bits_threads);
        return 1 << bits_threads;
    endfunction

    localparam int MW_NUM_THREADS = num_threads(MW_BITS_THREADS);

    localparam logic [1:0] RESULT_SRC_ALU = 2'd0;
    localparam logic [1:0] RESULT_SRC_MEM = 2'd1;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'd2;

    typedef struct packed {
        logic                        reg_write;
        logic [1:0]                  result_src;
        logic [MW_DATA_WIDTH-1:0]    alu_result;
        logic [MW_DATA_WIDTH-1:0]    read_data;
        logic [MW_REG_ADDR_W-1:0]    rd;
        logic [MW_ADDRESS_WIDTH-1:0] pc_plus4;
        logic [MW_BITS_THREADS-1:0]  tid;
    } mw_payload_t;

endpackage

// File: rtl/pl_elastic_fifo.sv
// Generic in-order DEPTH x WIDTH buffer with occupancy count and a sticky
// per-entry kill bit set by matching each entry's tag against a kill mask.
module pl_elastic_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    parameter int TAG_W = 3
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic [TAG_W-1:0]        push_tag,
    input  logic                    pop,
    input  logic [(1<<TAG_W)-1:0]   kill_mask,
    output logic [WIDTH-1:0]        head_data,
    output logic [TAG_W-1:0]        head_tag,
    output logic                    head_killed,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] killed_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            killed_q <= '0;
            // NOTE: storage is cleared too so the head outputs are defined zeros after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && kill_mask[tag_q[i]]) killed_q[i] <= 1'b1;
            end
            // NOTE: the pop below is a later non-blocking write, so it overrides a kill set on the same slot.
            if (pop) begin
                valid_q[rd_ptr]  <= 1'b0;
                killed_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                mem[wr_ptr]      <= push_data;
                tag_q[wr_ptr]    <= push_tag;
                valid_q[wr_ptr]  <= 1'b1;
                killed_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (!push && pop) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    assign head_data   = mem[rd_ptr];
    assign head_tag    = tag_q[rd_ptr];
    assign head_killed = killed_q[rd_ptr];
    assign full        = (count_q == FULL_COUNT);
    assign empty       = (count_q == '0);
    assign count       = count_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (clr) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (clr) !(pop && empty));
    a_count_bound:  assert property (@(posedge clk) count_q <= FULL_COUNT);

endmodule

// File: rtl/pl_reg_mw_elastic.sv
// MEM->WB elastic stage: valid/ready on both sides, in-order buffering and
// per-thread selective flush of in-flight and incoming beats.
module pl_reg_mw_elastic
    import pl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BITS_THREADS  = 3,
    parameter int DEPTH         = 2
) (
    input  logic                              clk,
    input  logic                              clr,
    input  logic                              valid_m,
    output logic                              ready_m,
    input  logic                              reg_write_m,
    input  logic [1:0]                        result_src_m,
    input  logic [DATA_WIDTH-1:0]             alu_result_m,
    input  logic [DATA_WIDTH-1:0]             read_data_m,
    input  logic [4:0]                        rd_m,
    input  logic [ADDRESS_WIDTH-1:0]          pc_plus4_m,
    input  logic [BITS_THREADS-1:0]           tid_m,
    input  logic [num_threads(BITS_THREADS)-1:0] flush_mask,
    output logic                              valid_w,
    input  logic                              ready_w,
    output logic                              reg_write_w,
    output logic [1:0]                        result_src_w,
    output logic [DATA_WIDTH-1:0]             alu_result_w,
    output logic [DATA_WIDTH-1:0]             read_data_w,
    output logic [4:0]                        rd_w,
    output logic [ADDRESS_WIDTH-1:0]          pc_plus4_w,
    output logic [BITS_THREADS-1:0]           tid_w,
    output logic [$clog2(DEPTH):0]            count
);

    localparam int PW = 1 + 2 + 2*DATA_WIDTH + 5 + ADDRESS_WIDTH + BITS_THREADS;

    logic                     push, pop, full, empty;
    logic                     head_killed, head_flushed, head_live;
    logic [PW-1:0]            push_data, head_data;
    logic [BITS_THREADS-1:0]  head_tag;

    logic                     h_reg_write;
    logic [1:0]               h_result_src;
    logic [DATA_WIDTH-1:0]    h_alu_result, h_read_data;
    logic [4:0]               h_rd;
    logic [ADDRESS_WIDTH-1:0] h_pc_plus4;
    logic [BITS_THREADS-1:0]  h_tid;

    assign push_data = {reg_write_m, result_src_m, alu_result_m, read_data_m,
                        rd_m, pc_plus4_m, tid_m};
    assign {h_reg_write, h_result_src, h_alu_result, h_read_data,
            h_rd, h_pc_plus4, h_tid} = head_data;

    // A beat of a thread being flushed completes its handshake but is never stored.
    assign ready_m      = !full;
    assign push         = valid_m && !full && !flush_mask[tid_m];
    assign head_flushed = flush_mask[head_tag];
    assign head_live    = !empty && !head_killed && !head_flushed;
    assign pop          = !empty && (ready_w || head_killed || head_flushed);

    pl_elastic_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW),
        .TAG_W (BITS_THREADS)
    ) u_fifo (
        .clk         (clk),
        .clr         (clr),
        .push        (push),
        .push_data   (push_data),
        .push_tag    (tid_m),
        .pop         (pop),
        .kill_mask   (flush_mask),
        .head_data   (head_data),
        .head_tag    (head_tag),
        .head_killed (head_killed),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    always_comb begin
        valid_w      = head_live;
        reg_write_w  = head_live && h_reg_write;
        result_src_w = empty ? '0 : h_result_src;
        alu_result_w = empty ? '0 : h_alu_result;
        read_data_w  = empty ? '0 : h_read_data;
        rd_w         = empty ? '0 : h_rd;
        pc_plus4_w   = empty ? '0 : h_pc_plus4;
        tid_w        = empty ? '0 : h_tid;
    end

endmodule

// File: tb/tb_pl_reg_mw_elastic.sv
// Bench for pl_reg_mw_elastic: DEPTH=2 and DEPTH=4 instances on shared stimulus,
// each checked every cycle against a queue model, plus directed literal checks.
module tb_pl_reg_mw_elastic;
    import pl_pkg::*;

    typedef struct packed {
        mw_payload_t p;
        logic        killed;
    } ent_t;

    logic        clk = 1'b0;
    logic        clr, valid_m, reg_write_m, ready_w;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [2:0]  tid_m;
    logic [7:0]  flush_mask;

    logic        vw [2];
    logic        rm [2];
    logic        rwr[2];
    logic [1:0]  rs [2];
    logic [31:0] alu[2];
    logic [31:0] rdt[2];
    logic [31:0] pc [2];
    logic [4:0]  rdw[2];
    logic [2:0]  tw [2];
    logic [2:0]  cnt[2];
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    assign cnt[0] = {1'b0, cnt2};
    assign cnt[1] = cnt4;

    int checks = 0;
    int errors = 0;
    ent_t q[2][$];
    logic last_ready0;

    always #5 clk = ~clk;

    pl_reg_mw_elastic #(.DEPTH(2)) u_dut2 (
        .clk(clk), .clr(clr), .valid_m(valid_m), .ready_m(rm[0]),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .tid_m(tid_m),
        .flush_mask(flush_mask), .valid_w(vw[0]), .ready_w(ready_w),
        .reg_write_w(rwr[0]), .result_src_w(rs[0]), .alu_result_w(alu[0]),
        .read_data_w(rdt[0]), .rd_w(rdw[0]), .pc_plus4_w(pc[0]), .tid_w(tw[0]), .count(cnt2)
    );

    pl_reg_mw_elastic #(.DEPTH(4)) u_dut4 (
        .clk(clk), .clr(clr), .valid_m(valid_m), .ready_m(rm[1]),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
        .read_data_m(read_data_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .tid_m(tid_m),
        .flush_mask(flush_mask), .valid_w(vw[1]), .ready_w(ready_w),
        .reg_write_w(rwr[1]), .result_src_w(rs[1]), .alu_result_w(alu[1]),
        .read_data_w(rdt[1]), .rd_w(rdw[1]), .pc_plus4_w(pc[1]), .tid_w(tw[1]), .count(cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input logic v, input logic [4:0] rd, input logic [2:0] tid,
                        input logic [31:0] a, input logic [7:0] fm, input logic rw);
        clr          = 1'b0;
        valid_m      = v;
        reg_write_m  = 1'b1;
        result_src_m = RESULT_SRC_MEM;
        alu_result_m = a;
        read_data_m  = ~a;
        rd_m         = rd;
        pc_plus4_m   = a + 32'd4;
        tid_m        = tid;
        flush_mask   = fm;
        ready_w      = rw;
    endtask

    // Compare both instances against the queue model, then advance the model
    // by the effect of the coming clock edge.
    task automatic eval();
        #1;
        for (int k = 0; k < 2; k++) begin
            int   sz  = q[k].size();
            int   dep = (k == 0) ? 2 : 4;
            ent_t h   = '0;
            logic hk  = 1'b0;
            logic e_ready, e_valid, do_pop, do_push;
            string tag = $sformatf("d%0d", dep);
            if (sz != 0) begin
                h  = q[k][0];
                hk = h.killed || flush_mask[h.p.tid];
            end
            e_ready = (sz < dep);
            e_valid = (sz != 0) && !hk;
            check({tag, " valid_w"},      vw[k],  e_valid);
            check({tag, " ready_m"},      rm[k],  e_ready);
            check({tag, " count"},        cnt[k], sz);
            check({tag, " reg_write_w"},  rwr[k], e_valid && h.p.reg_write);
            check({tag, " result_src_w"}, rs[k],  h.p.result_src);
            check({tag, " alu_result_w"}, alu[k], h.p.alu_result);
            check({tag, " read_data_w"},  rdt[k], h.p.read_data);
            check({tag, " rd_w"},         rdw[k], h.p.rd);
            check({tag, " pc_plus4_w"},   pc[k],  h.p.pc_plus4);
            check({tag, " tid_w"},        tw[k],  h.p.tid);
            if (k == 0) last_ready0 = e_ready;
            if (clr) begin
                q[k].delete();
            end else begin
                do_pop  = (sz != 0) && (hk || ready_w);
                do_push = valid_m && e_ready && !flush_mask[tid_m];
                for (int i = 0; i < q[k].size(); i++) begin
                    ent_t e = q[k][i];
                    if (flush_mask[e.p.tid]) e.killed = 1'b1;
                    q[k][i] = e;
                end
                if (do_pop) void'(q[k].pop_front());
                if (do_push) begin
                    ent_t n;
                    n.p = '{reg_write: reg_write_m, result_src: result_src_m,
                            alu_result: alu_result_m, read_data: read_data_m,
                            rd: rd_m, pc_plus4: pc_plus4_m, tid: tid_m};
                    n.killed = 1'b0;
                    q[k].push_back(n);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) begin
            beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
            eval();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        clr = 1'b1;
        tick();
        tick();
        tick();
        clr = 1'b0;

        // Idle after reset
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("rst valid_w", vw[0], 1'b0);
        check("rst ready_m", rm[0], 1'b1);
        check("rst count",   cnt[0], 3'd0);
        tick();

        // Streaming: each beat visible one cycle after its push
        beat(1'b1, 5'd1, 3'd1, 32'd1, 8'h00, 1'b1);
        eval();
        tick();
        for (int i = 2; i <= 8; i++) begin
            beat(1'b1, 5'(i), 3'(i % 8), 32'(i), 8'h00, 1'b1);
            eval();
            check("stream rd_w",    rdw[0], 5'(i - 1));
            check("stream valid_w", vw[0], 1'b1);
            check("stream ready_m", rm[0], 1'b1);
            tick();
        end
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
        eval();
        check("stream last rd_w", rdw[0], 5'd8);
        tick();
        drain();

        // Backpressure until full, then release
        beat(1'b1, 5'd5, 3'd0, 32'd5, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd6, 3'd0, 32'd6, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd7, 3'd0, 32'd7, 8'h00, 1'b0);
        eval();
        check("full count",   cnt[0], 3'd2);
        check("full ready_m", rm[0], 1'b0);
        check("full rd_w",    rdw[0], 5'd5);
        tick();
        beat(1'b1, 5'd7, 3'd0, 32'd7, 8'h00, 1'b1);
        eval();
        check("full ready_m with ready_w", rm[0], 1'b0);
        check("release rd_w 5", rdw[0], 5'd5);
        tick();
        beat(1'b1, 5'd7, 3'd0, 32'd7, 8'h00, 1'b1);
        eval();
        check("release rd_w 6", rdw[0], 5'd6);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
        eval();
        check("release rd_w 7", rdw[0], 5'd7);
        check("release valid_w", vw[0], 1'b1);
        tick();
        drain();

        // Selective flush of the head thread
        beat(1'b1, 5'd3, 3'd2, 32'h30, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd9, 3'd4, 32'h90, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'b0000_0100, 1'b0);
        eval();
        check("flush head hidden", vw[0], 1'b0);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("flush next valid_w", vw[0], 1'b1);
        check("flush next rd_w",    rdw[0], 5'd9);
        check("flush next tid_w",   tw[0], 3'd4);
        check("flush next count",   cnt[0], 3'd1);
        tick();
        drain();

        // Sticky kill of a non-head entry drains without ready_w
        beat(1'b1, 5'd1, 3'd1, 32'h11, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd2, 3'd2, 32'h22, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h04, 1'b0);
        eval();
        check("kill head still live", vw[0], 1'b1);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
        eval();
        check("kill pop rd_w", rdw[0], 5'd1);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("killed valid_w",     vw[0], 1'b0);
        check("killed reg_write_w", rwr[0], 1'b0);
        check("killed rd_w",        rdw[0], 5'd2);
        check("killed count",       cnt[0], 3'd1);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("killed drained", cnt[0], 3'd0);
        tick();
        drain();

        // Incoming beat of a flushed thread is swallowed
        beat(1'b1, 5'd12, 3'd6, 32'h66, 8'b0100_0000, 1'b0);
        eval();
        check("inflush ready_m", rm[0], 1'b1);
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("inflush count",   cnt[0], 3'd0);
        check("inflush valid_w", vw[0], 1'b0);
        tick();
        drain();

        // Reset mid-traffic
        beat(1'b1, 5'd10, 3'd1, 32'hA0, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd11, 3'd2, 32'hB0, 8'h00, 1'b0);
        eval();
        tick();
        beat(1'b1, 5'd20, 3'd3, 32'hC0, 8'h00, 1'b0);
        clr = 1'b1;
        eval();
        tick();
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b0);
        eval();
        check("clr count",        cnt[0], 3'd0);
        check("clr valid_w",      vw[0], 1'b0);
        check("clr ready_m",      rm[0], 1'b1);
        check("clr rd_w",         rdw[0], 5'd0);
        check("clr alu_result_w", alu[0], 32'd0);
        check("clr pc_plus4_w",   pc[0], 32'd0);
        check("clr tid_w",        tw[0], 3'd0);
        tick();
        drain();

        // Pointer wrap on the DEPTH=4 instance
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 5'(i + 1), 3'(i % 8), 32'h1000 + 32'(i), 8'h00, 1'b1);
            eval();
            if (i > 0) begin
                check("wrap alu_result_w", alu[1], 32'h1000 + 32'(i - 1));
                check("wrap count",        cnt[1], 3'd1);
            end
            tick();
        end
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
        eval();
        check("wrap last alu_result_w", alu[1], 32'h1009);
        tick();
        drain();

        // Randomized traffic; an unaccepted beat is held stable by the source
        beat(1'b0, 5'd0, 3'd0, 32'd0, 8'h00, 1'b1);
        last_ready0 = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (!(valid_m && !last_ready0)) begin
                valid_m      = ($urandom_range(0, 3) != 0);
                reg_write_m  = 1'($urandom);
                result_src_m = 2'($urandom_range(0, 2));
                alu_result_m = $urandom;
                read_data_m  = $urandom;
                rd_m         = 5'($urandom);
                pc_plus4_m   = $urandom;
                tid_m        = 3'($urandom);
            end
            r = $urandom_range(0, 31);
            if (r == 0)      flush_mask = 8'($urandom);
            else if (r == 1) flush_mask = 8'hFF;
            else if (r < 4)  flush_mask = 8'(1 << $urandom_range(0, 7));
            else             flush_mask = 8'h00;
            ready_w = ($urandom_range(0, 9) < 7);
            clr     = ($urandom_range(0, 299) == 0);
            eval();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
